// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Digit-serial subtractor that computes minuend - subtrahend - borrow_in on
// WIDTH-bit operands. It processes DIGIT bits per clock, least significant
// digit first. A single borrow register carries the borrow between digits.
// A separate result register keeps the previous result visible while a new
// operation runs.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_start        request a new operation (ignored while o_busy)
//   i_minuend      operand A, captured on the accepting edge
//   i_subtrahend   operand B, captured on the accepting edge
//   i_borrow_in    initial borrow, captured on the accepting edge
//   o_busy         operation in progress
//   o_done         one-cycle pulse, results valid from this cycle
//   o_diff         A - B - borrow_in modulo 2^WIDTH
//   o_borrow_out   final borrow (unsigned A < B + borrow_in)
//   o_overflow     two's-complement overflow of the signed subtraction
//   o_zero         o_diff == 0
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    input  logic             i_borrow_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int unsigned ND   = WIDTH / DIGIT;
    localparam int unsigned CW   = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             r_busy;
    logic             r_done;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;

    logic [WIDTH-1:0] r_res_diff;
    logic             r_res_borrow;
    logic             r_res_ov;
    logic             r_res_zero;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_d_dig;
    logic             w_b_out;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [WIDTH-1:0] w_diff_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so busy/done are flops
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN:   w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign w_run    = (r_state == S_RUN);
    assign w_accept = (r_state != S_RUN) && i_start;
    assign w_last   = w_run && (r_cnt == LAST);
    assign w_a_dig  = r_a[DIGIT-1:0];
    assign w_b_dig  = r_b[DIGIT-1:0];

    // DIGIT-bit ripple of full-subtractor cells, seeded by the borrow register
    always_comb begin
        logic bw;
        bw      = r_borrow;
        w_d_dig = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            w_d_dig[i] = w_a_dig[i] ^ w_b_dig[i] ^ bw;
            bw         = (~w_a_dig[i] & w_b_dig[i]) | (~(w_a_dig[i] ^ w_b_dig[i]) & bw);
        end
        w_b_out = bw;
    end

    // Operands shift right one digit per step; diff digits enter from the MSB end
    if (DIGIT < WIDTH) begin : g_multi
        assign w_a_shift  = {DIGIT'(0), r_a[WIDTH-1:DIGIT]};
        assign w_b_shift  = {DIGIT'(0), r_b[WIDTH-1:DIGIT]};
        assign w_diff_nxt = {w_d_dig, r_diff[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign w_a_shift  = '0;
        assign w_b_shift  = '0;
        assign w_diff_nxt = w_d_dig;
    end

    // Working datapath: load on accept, one digit per RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_minuend;
            r_b      <= i_subtrahend;
            r_diff   <= '0;
            r_borrow <= i_borrow_in;
            r_cnt    <= '0;
            r_a_msb  <= i_minuend[WIDTH-1];
            r_b_msb  <= i_subtrahend[WIDTH-1];
        end else if (w_run) begin
            r_a      <= w_a_shift;
            r_b      <= w_b_shift;
            r_diff   <= w_diff_nxt;
            r_borrow <= w_b_out;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Result register: only updated on the edge that finishes the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_diff   <= '0;
            r_res_borrow <= 1'b0;
            r_res_ov     <= 1'b0;
            r_res_zero   <= 1'b0;
        end else if (w_last) begin
            r_res_diff   <= w_diff_nxt;
            r_res_borrow <= w_b_out;
            r_res_ov     <= (r_a_msb ^ r_b_msb) & (w_diff_nxt[WIDTH-1] ^ r_a_msb);
            r_res_zero   <= (w_diff_nxt == '0);
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_diff       = r_res_diff;
    assign o_borrow_out = r_res_borrow;
    assign o_overflow   = r_res_ov;
    assign o_zero       = r_res_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Bench for serial_subtractor. Instance 0 uses DIGIT=4 (ND=4). Instance 1 uses
// DIGIT=1 (ND=16). Instance 2 uses DIGIT=16 (ND=1). A cycle-level reference
// for instance 0 is checked on every falling edge. Directed and random
// operations check results and latency on all three instances.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [2:0]          start_v;
    logic [2:0]          bin_v;
    logic [2:0]          busy_v;
    logic [2:0]          done_v;
    logic [2:0]          bo_v;
    logic [2:0]          ov_v;
    logic [2:0]          z_v;
    logic [2:0][W-1:0]   a_v;
    logic [2:0][W-1:0]   b_v;
    logic [2:0][W-1:0]   diff_v;

    int n_total = 0;
    int n_pass  = 0;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start_v[0]), .i_minuend(a_v[0]),
        .i_subtrahend(b_v[0]), .i_borrow_in(bin_v[0]), .o_busy(busy_v[0]),
        .o_done(done_v[0]), .o_diff(diff_v[0]), .o_borrow_out(bo_v[0]),
        .o_overflow(ov_v[0]), .o_zero(z_v[0])
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start_v[1]), .i_minuend(a_v[1]),
        .i_subtrahend(b_v[1]), .i_borrow_in(bin_v[1]), .o_busy(busy_v[1]),
        .o_done(done_v[1]), .o_diff(diff_v[1]), .o_borrow_out(bo_v[1]),
        .o_overflow(ov_v[1]), .o_zero(z_v[1])
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start_v[2]), .i_minuend(a_v[2]),
        .i_subtrahend(b_v[2]), .i_borrow_in(bin_v[2]), .o_busy(busy_v[2]),
        .o_done(done_v[2]), .o_diff(diff_v[2]), .o_borrow_out(bo_v[2]),
        .o_overflow(ov_v[2]), .o_zero(z_v[2])
    );

    function automatic int nd_of(input int u);
        case (u)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    // {borrow_out, overflow, zero, diff}
    function automatic logic [18:0] pack(input logic bo, input logic ov, input logic z,
                                         input logic [15:0] d);
        return {bo, ov, z, d};
    endfunction

    // Plain arithmetic: 17-bit wrap gives the borrow in bit 16
    function automatic logic [18:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic bin);
        logic [16:0] t;
        logic        ov;
        t  = {1'b0, a} - {1'b0, b} - 17'(bin);
        ov = (a[15] != b[15]) && (t[15] != a[15]);
        return {t[16], ov, (t[15:0] == 16'h0000), t[15:0]};
    endfunction

    function automatic logic [18:0] res_of(input int u);
        return {bo_v[u], ov_v[u], z_v[u], diff_v[u]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Cycle-level reference for instance 0: accept when idle, done ND edges later
    logic        m_busy;
    logic        m_done;
    int          m_left;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_bin;
    logic [18:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= ref_result(m_a, m_b, m_bin);
            end
        end else begin
            m_done <= 1'b0;
            if (start_v[0]) begin
                m_busy <= 1'b1;
                m_left <= nd_of(0);
                m_a    <= a_v[0];
                m_b    <= b_v[0];
                m_bin  <= bin_v[0];
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle_u0", 32'({busy_v[0], done_v[0], res_of(0)}),
            32'({m_busy, m_done, m_res}));
    end

    // Drive one start pulse, then scramble operands (must not affect the result)
    task automatic launch(input int u, input logic [15:0] a, input logic [15:0] b,
                          input logic bin);
        a_v[u]     = a;
        b_v[u]     = b;
        bin_v[u]   = bin;
        start_v[u] = 1'b1;
        @(posedge clk);
        #1;
        start_v[u] = 1'b0;
        a_v[u]     = 16'($urandom);
        b_v[u]     = 16'($urandom);
        bin_v[u]   = 1'($urandom);
    endtask

    // Called just after the accepting edge; optional ignored start at edge index inj
    task automatic wait_done(input int u, input int inj, input string nm, output bit ok);
        int edges;
        int busy_n;
        int nd;
        edges  = 0;
        busy_n = 0;
        nd     = nd_of(u);
        ok     = 1'b0;
        for (int i = 0; i < nd + 20; i++) begin
            start_v[u] = (edges == inj);
            if (edges == inj) a_v[u] = 16'hFFFF;
            if (busy_v[u]) busy_n++;
            if (done_v[u]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start_v[u] = 1'b0;
        if (!ok) $display("FAIL %s_timeout: done not seen within %0d edges", nm, nd + 20);
        chk({nm, "_latency_busy"}, 32'({ok, 15'(edges), 16'(busy_n)}),
            32'({1'b1, 15'(nd), 16'(nd)}));
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] special [5];
        special[0] = 16'h0000;
        special[1] = 16'hFFFF;
        special[2] = 16'h8000;
        special[3] = 16'h7FFF;
        special[4] = 16'h0001;
        if ($urandom_range(0, 7) == 0) return special[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        bit ok;
        rst_n   = 1'b0;
        start_v = '0;
        bin_v   = '0;
        a_v     = '0;
        b_v     = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++)
            chk($sformatf("reset_outputs_u%0d", u), 32'({busy_v[u], done_v[u], res_of(u)}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++)
            chk($sformatf("idle_after_reset_u%0d", u), 32'({busy_v[u], done_v[u]}), 32'd0);

        // Directed operations on instance 0
        launch(0, 16'h1234, 16'h0234, 1'b0);
        wait_done(0, -1, "basic", ok);
        chk("basic", 32'(res_of(0)), 32'(pack(1'b0, 1'b0, 1'b0, 16'h1000)));

        launch(0, 16'h0000, 16'h0001, 1'b0);
        wait_done(0, -1, "borrow", ok);
        chk("borrow", 32'(res_of(0)), 32'(pack(1'b1, 1'b0, 1'b0, 16'hFFFF)));

        launch(0, 16'h0005, 16'h0004, 1'b1);
        wait_done(0, -1, "zero", ok);
        chk("zero", 32'(res_of(0)), 32'(pack(1'b0, 1'b0, 1'b1, 16'h0000)));

        launch(0, 16'h8000, 16'h0001, 1'b0);
        wait_done(0, -1, "ovf_neg", ok);
        chk("ovf_neg", 32'(res_of(0)), 32'(pack(1'b0, 1'b1, 1'b0, 16'h7FFF)));

        launch(0, 16'h7FFF, 16'hFFFF, 1'b0);
        wait_done(0, -1, "ovf_pos", ok);
        chk("ovf_pos", 32'(res_of(0)), 32'(pack(1'b1, 1'b1, 1'b0, 16'h8000)));

        // Start pulse sampled at t0+2 while busy must be ignored
        launch(0, 16'h1234, 16'h0234, 1'b0);
        wait_done(0, 1, "ignored_start", ok);
        chk("ignored_start", 32'(res_of(0)), 32'(pack(1'b0, 1'b0, 1'b0, 16'h1000)));

        // Back-to-back start in the done cycle; previous diff held during RUN
        launch(0, 16'h0010, 16'h0001, 1'b0);
        chk("b2b_hold", 32'({busy_v[0], done_v[0], diff_v[0]}), 32'({1'b1, 1'b0, 16'h1000}));
        wait_done(0, -1, "b2b", ok);
        chk("b2b", 32'(res_of(0)), 32'(pack(1'b0, 1'b0, 1'b0, 16'h000F)));

        // Reset in the middle of an operation
        launch(0, 16'h5555, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", 32'({busy_v[0], done_v[0], res_of(0)}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        launch(0, 16'h00FF, 16'h000F, 1'b0);
        wait_done(0, -1, "after_reset", ok);
        chk("after_reset", 32'(res_of(0)), 32'(pack(1'b0, 1'b0, 1'b0, 16'h00F0)));

        // Random operations on all three digit widths
        for (int u = 0; u < 3; u++) begin
            int n_ops;
            n_ops = (u == 0) ? 3000 : ((u == 1) ? 300 : 1000);
            for (int i = 0; i < n_ops; i++) begin
                logic [15:0] a;
                logic [15:0] b;
                logic        bi;
                a  = pick();
                b  = pick();
                bi = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                launch(u, a, b, bi);
                wait_done(u, -1, $sformatf("rand_u%0d", u), ok);
                if (ok)
                    chk($sformatf("rand_u%0d_result", u), 32'(res_of(u)),
                        32'(ref_result(a, b, bi)));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
